mux_scan_reg: RTL
=================

# mux_scan_reg

Parametrised N-channel selecting register with a run sequencer. It captures one of `CHANNELS` input words per clock into a registered output. Channel selection is either fixed by a select input or auto-scanned round-robin. A capture run lasts for a programmed number of cycles and ends with a done pulse. It generalises the existing 2:1 enable-mux register and clock-count demo into a reusable datapath sampler for bench and demo designs.

## Interface
- `WIDTH`, 8, data word width (≥1)
- `CHANNELS`, 4, number of input channels (2..16)
- `SEL_W`, 2, select/channel-index width; must satisfy 2^SEL_W ≥ CHANNELS
- `clk` in 1, single clock; all state updates on posedge
- `rst_n` in 1, reset, asynchronous, active-low
- `start` in 1, begin a run; sampled only in IDLE
- `mode` in 1, 0 = manual (use `sel_in`), 1 = scan (round-robin from channel 0); sampled with `start`
- `sel_in` in SEL_W, manual channel select; sampled with `start`
- `din` in CHANNELS*WIDTH, channel k occupies bits [k*WIDTH +: WIDTH]
- `run_len` in 8, number of captures in the run; sampled with `start`
- `hold` in 1, freeze request (see Configuration)
- `q` out WIDTH, captured word
- `q_valid` out 1, high for each cycle `q` holds a capture made on the preceding edge during the run
- `ch` out SEL_W, channel index of the word currently in `q`
- `cycle_cnt` out 8, captures completed in the current/last run
- `busy` out 1, high in RUN
- `done` out 1, one-cycle pulse in DONE

## Operation
- Reset values: `q`=0, `q_valid`=0, `ch`=0, `cycle_cnt`=0, `busy`=0, `done`=0, state=IDLE, internal pointer=0, latched length=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 and `run_len`≠0: latch `mode` and `run_len`. Load the pointer with 0 in scan mode or `sel_in` in manual mode; clamp manual `sel_in` ≥ CHANNELS to CHANNELS-1. Clear `cycle_cnt` and go to RUN.
  - `start`=1 and `run_len`=0: go directly to DONE. No capture occurs and `cycle_cnt` is cleared.
- RUN, each edge:
  - `q`←din[pointer], `ch`←pointer, `q_valid`←1, `cycle_cnt`←cycle_cnt+1.
  - Scan mode: pointer←(pointer+1) mod CHANNELS, wrapping CHANNELS-1→0. Manual mode: pointer is unchanged.
  - When `cycle_cnt`+1 equals the latched length, go to DONE on the same edge.
- DONE: `done`=1 and `q_valid` is cleared. Go to IDLE on the next edge.
- `q`, `ch` and `cycle_cnt` hold their values after the run until the next run's captures.
- `start` in RUN or DONE is ignored. Changes to `mode`, `sel_in` or `run_len` mid-run have no effect.
- Reset asserted mid-run returns all outputs to reset values immediately, with no done pulse.
- `cycle_cnt` is 8-bit. A run of 255 is the maximum and never wraps.

## Timing
- Start accepted at edge T (IDLE→RUN). First capture at edge T+1, so `q_valid` is high after T+1.
- Capture n occurs at edge T+n. The last capture is at T+run_len, which also moves the state to DONE.
- `done` and `busy`:
  - `done` is high from edge T+run_len+1 to T+run_len+2.
  - `busy` is high from T+1 through T+run_len.
  - `q_valid` is high between edges T+1 and T+run_len+1.
- Moore outputs only; there are no combinational paths from inputs to outputs.
- A new `start` is accepted at the earliest at edge T+run_len+2, when the block is back in IDLE.

## Configuration
- `MUX_SCAN_HOLD_EN` defined:
  - `hold`=1 in RUN freezes the pointer, `cycle_cnt`, `q`, `ch` and state.
  - `q_valid` is driven 0 while held.
  - Capture resumes on the first edge after `hold` deasserts.
  - `hold` in IDLE or DONE has no effect.
- `MUX_SCAN_HOLD_EN` undefined: `hold` is ignored and RUN advances every edge.

## Test plan
- Reset:
  - Stimulus: drive `rst_n`=0 with random `din`.
  - Required: all outputs 0.
  - Stimulus: release `rst_n` with `start`=0 for 5 cycles.
  - Required: outputs stay 0 and state stays IDLE.
- Manual mode:
  - Stimulus: CHANNELS=4, WIDTH=8, din={8'd4,8'd3,8'd2,8'd1}, `sel_in`=2, `run_len`=3, pulse `start`.
  - Required: `q`=3 with `ch`=2 for 3 captures, `cycle_cnt` counts 1,2,3, then `done` high exactly 1 cycle.
- Scan wrap:
  - Stimulus: same `din`, `mode`=1, `run_len`=6.
  - Required: `q` sequence 1,2,3,4,1,2 and `ch` sequence 0,1,2,3,0,1; `busy` high 6 cycles.
- Boundary cases:
  - Stimulus: `run_len`=0.
    Required: no `q_valid`, `done` pulses the cycle after start, `q` unchanged.
  - Stimulus: `sel_in`=3 with CHANNELS=3.
    Required: clamped to channel 2.
  - Stimulus: `start` held high throughout.
    Required: back-to-back runs separated by a DONE cycle and one IDLE edge.
- Reset mid-run:
  - Stimulus: assert `rst_n`=0 asynchronously at capture 2 of a 5-capture scan.
  - Required: outputs 0 immediately and no `done`.
- Hold (with `MUX_SCAN_HOLD_EN`):
  - Stimulus: scan with `run_len`=4, `hold`=1 for 2 cycles after capture 1.
  - Required: `q_valid`=0 and `ch` frozen while held, captures resume at channel 1, and `done` is delayed 2 cycles.
  - Required without the macro: identical timing to the unheld run.

Source files
------------

// File: rtl/mux_scan_reg.sv
// mux_scan_reg -- N-channel selecting register with a run sequencer.
//
// Each cycle of a run, one WIDTH-bit word is captured from din into q. The
// captured channel is either fixed (manual mode, from sel_in) or stepped
// round-robin from channel 0 (scan mode). A run lasts run_len captures.
// After the last capture the block passes through DONE and returns to IDLE.
//
// Optional feature: define MUX_SCAN_HOLD_EN to let `hold` freeze a run.
// Without the macro, `hold` is ignored.
//
// Ports:
//   clk        single clock, posedge
//   rst_n      asynchronous active-low reset
//   start      begin a run (sampled in IDLE only)
//   mode       0 = manual (sel_in), 1 = scan; sampled with start
//   sel_in     manual channel select; clamped to CHANNELS-1; sampled with start
//   din        CHANNELS packed words, channel k at [k*WIDTH +: WIDTH]
//   run_len    number of captures; 0 goes straight to DONE
//   hold       freeze request (MUX_SCAN_HOLD_EN builds only)
//   q          captured word
//   q_valid    q holds a capture made on the preceding edge
//   ch         channel index of the word in q
//   cycle_cnt  captures completed in the current/last run
//   busy       run in progress
//   done       one-cycle end-of-run pulse
//
// All outputs are registered. busy and done are state flags registered from
// the current state, so they lag the state register by one edge.
module mux_scan_reg #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [7:0]                run_len,
  input  logic                      hold,
  output logic [WIDTH-1:0]          q,
  output logic                      q_valid,
  output logic [SEL_W-1:0]          ch,
  output logic [7:0]                cycle_cnt,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic             mode_r;
  logic [7:0]       len_r;

  logic [WIDTH-1:0] sel_word;
  logic [SEL_W-1:0] sel_clamped;
  logic [SEL_W-1:0] ptr_next;
  logic             held;

`ifdef MUX_SCAN_HOLD_EN
  assign held = hold;
`else
  logic unused_hold;
  assign unused_hold = hold;
  assign held        = 1'b0;
`endif

  // Word mux and pointer arithmetic.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ptr == SEL_W'(k)) sel_word = din[k*WIDTH +: WIDTH];
    end

    sel_clamped = sel_in;
    if (int'(sel_in) >= CHANNELS) sel_clamped = SEL_W'(CHANNELS - 1);

    ptr_next = ptr + 1'b1;
    if (ptr == SEL_W'(CHANNELS - 1)) ptr_next = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      mode_r    <= 1'b0;
      len_r     <= '0;
      q         <= '0;
      q_valid   <= 1'b0;
      ch        <= '0;
      cycle_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy    <= (state == S_RUN);
      done    <= (state == S_DONE);
      q_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            cycle_cnt <= '0;
            if (run_len != 8'd0) begin
              mode_r <= mode;
              len_r  <= run_len;
              ptr    <= mode ? '0 : sel_clamped;
              state  <= S_RUN;
            end else begin
              state <= S_DONE;
            end
          end
        end

        S_RUN: begin
          if (!held) begin
            q         <= sel_word;
            ch        <= ptr;
            q_valid   <= 1'b1;
            cycle_cnt <= cycle_cnt + 8'd1;
            if (mode_r) ptr <= ptr_next;
            // len_r <= 255, so cycle_cnt never wraps.
            if (cycle_cnt + 8'd1 == len_r) state <= S_DONE;
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
